// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with a 2-entry skid buffer and a registered in_ready.
// Define PIPE_PERF_CNT_EN to add the stall_cnt/bubble_cnt performance counters.
//   state    | meaning
//   ST_EMPTY | main invalid, skid empty
//   ST_ONE   | main valid, skid empty
//   ST_TWO   | main and skid both valid, upstream held off
module pipe_stage_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic                w_in_fire;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid_in;

    if (CNT_W < 1 || CTRL_W < 1 || DATA_W < 1) begin : g_bad_width
        $error("pipe_stage_reg: widths must be at least 1");
    end

    assign w_in_fire = in_valid & r_in_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_fire && out_ready) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid_in = 1'b1;
                    w_state_nxt    = ST_TWO;
                end else if (out_ready) begin
                    w_state_nxt    = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_ready) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // Flush drops everything held and whatever arrives this cycle.
        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid_in   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
            if (w_load_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid_in) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_ctrl  = out_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (!out_valid && r_bubble_cnt != '1)
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg: a FIFO reference model of capacity two
// predicts occupancy, in_ready, output order and (when enabled) the counters.
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 128;
    localparam int NW = 4;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef PIPE_PERF_CNT_EN
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] bubble_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    bit   rst_seen = 1'b0;
    logic [NW-1:0] m_stall = '0;
    logic [NW-1:0] m_bubble = '0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: compares the DUT against the FIFO model, then advances the model
    // with the inputs that will be sampled at the coming rising edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_out_valid", DW'(out_valid), DW'(1'b0));
            chk("rst_in_ready", DW'(in_ready), DW'(1'b0));
            chk("rst_out_ctrl", DW'(out_ctrl), DW'(0));
`ifdef PIPE_PERF_CNT_EN
            chk("rst_stall_cnt", DW'(stall_cnt), DW'(0));
            chk("rst_bubble_cnt", DW'(bubble_cnt), DW'(0));
`endif
            q.delete();
            rst_seen = 1'b1;
            m_stall  = '0;
            m_bubble = '0;
        end else begin
            automatic bit exp_ready = rst_seen ? 1'b0 : (q.size() < 2);
            automatic bit occupied  = (q.size() != 0);
            chk("out_valid", DW'(out_valid), DW'(occupied));
            chk("in_ready", DW'(in_ready), DW'(exp_ready));
            if (occupied) begin
                chk("out_ctrl", DW'(out_ctrl), DW'(q[0].c));
                chk("out_data", out_data, q[0].d);
            end else begin
                chk("bubble_ctrl_zero", DW'(out_ctrl), DW'(0));
            end
`ifdef PIPE_PERF_CNT_EN
            chk("stall_cnt", DW'(stall_cnt), DW'(m_stall));
            chk("bubble_cnt", DW'(bubble_cnt), DW'(m_bubble));
`endif
            if (!occupied && m_bubble != '1) m_bubble = m_bubble + 1'b1;
            if (occupied && !out_ready && m_stall != '1) m_stall = m_stall + 1'b1;
            if (occupied && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready && !flush) q.push_back('{c: in_ctrl, d: in_data});
            if (flush) q.delete();
            rst_seen = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit v, input logic [DW-1:0] d, input bit ordy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = CW'($urandom) | CW'(1);
        out_ready = ordy;
    endtask

    // Asserts reset between edges, checks the outputs clear without a clock, releases after the next edge.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", DW'(out_valid), DW'(1'b0));
        chk("arst_out_ctrl", DW'(out_ctrl), DW'(0));
        chk("arst_in_ready", DW'(in_ready), DW'(1'b0));
        chk("arst_out_data", out_data, DW'(0));
        in_valid = 1'b0;
        flush    = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        put(1'b0, '0, 1'b0);
        repeat (3) step();
        reset = 1'b0;
        chk("idle_in_ready_low", DW'(in_ready), DW'(1'b0));
        step();
        chk("in_ready_after_release", DW'(in_ready), DW'(1'b1));
        chk("idle_out_valid", DW'(out_valid), DW'(1'b0));

        // Streaming at full throughput.
        for (int i = 1; i <= 4; i++) begin
            put(1'b1, DW'(i), 1'b1);
            step();
            chk("stream_data", out_data, DW'(i));
            chk("stream_ready", DW'(in_ready), DW'(1'b1));
        end
        put(1'b0, '0, 1'b1);
        repeat (2) step();

        // Back-pressure fills the skid entry.
        put(1'b1, DW'('hA), 1'b0);
        step();
        put(1'b1, DW'('hB), 1'b0);
        step();
        put(1'b0, '0, 1'b0);
        chk("bp_ready_low", DW'(in_ready), DW'(1'b0));
        chk("bp_head", out_data, DW'('hA));
        step();
        out_ready = 1'b1;
        step();
        chk("bp_second", out_data, DW'('hB));
        chk("bp_ready_back", DW'(in_ready), DW'(1'b1));
        repeat (2) step();

        // Flush while full, with a competing input.
        put(1'b1, DW'('h11), 1'b0);
        step();
        put(1'b1, DW'('h12), 1'b0);
        step();
        put(1'b1, DW'('hC), 1'b0);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", DW'(out_valid), DW'(1'b0));
        chk("flush_out_ctrl", DW'(out_ctrl), DW'(0));
        chk("flush_in_ready", DW'(in_ready), DW'(1'b1));
        repeat (3) step();

        // Asynchronous reset while full, then a fresh entry.
        put(1'b1, DW'('h21), 1'b0);
        step();
        put(1'b1, DW'('h22), 1'b0);
        step();
        in_valid = 1'b0;
        async_reset();
        put(1'b0, '0, 1'b1);
        step();
        put(1'b1, DW'('h5), 1'b1);
        step();
        chk("post_reset_entry", out_data, DW'('h5));
        in_valid = 1'b0;
        repeat (2) step();

`ifdef PIPE_PERF_CNT_EN
        // Two empty cycles then three stalled cycles from a fresh reset.
        async_reset();
        put(1'b1, DW'('h77), 1'b0);
        step();
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("cnt_stall_3", DW'(stall_cnt), DW'(3));
        chk("cnt_bubble_2", DW'(bubble_cnt), DW'(2));
        repeat (20) step();
        chk("cnt_stall_sat", DW'(stall_cnt), DW'({NW{1'b1}}));
        out_ready = 1'b1;
        repeat (2) step();
`endif

        // Random traffic with occasional flushes and one asynchronous reset.
        for (int i = 0; i < 1500; i++) begin
            put($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 31) == 0);
            if (i == 700) async_reset();
            else step();
        end
        flush = 1'b0;
        put(1'b0, '0, 1'b1);
        repeat (4) step();
        chk("drain_empty", DW'(q.size()), DW'(0));
        chk("drain_out_valid", DW'(out_valid), DW'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
